spawn_scheduler: RTL

- Paces obstacle and powerup spawns for the runner game and picks the lane for each one.
- Sits between the game state machine (playing, reset_game, time_alive, pulse) and the obstacle/powerup datapath.
- Offers one spawn at a time on a valid/ready handshake.
- Spawn interval shrinks as time_alive grows; every POWERUP_EVERY-th spawn is a powerup.

---
 rtl/game_pkg.sv | 40 ++++
 rtl/lfsr16.sv | 20 ++
 rtl/spawn_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the runner-game spawn logic.
//   sched_state_t : spawn scheduler FSM states
//   LANE_*        : lane encodings (LANE_NONE marks "no previous obstacle")
//   LFSR_MASK     : Galois feedback taps for the 16-bit lane LFSR
//   spawn_t       : one spawn offer (lane + kind)
//   pick_lane     : lane choice from raw LFSR bits and obstacle history
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    OFFER = 2'd2
  } sched_state_t;

  localparam logic [1:0] LANE_LEFT  = 2'd0;
  localparam logic [1:0] LANE_MID   = 2'd1;
  localparam logic [1:0] LANE_RIGHT = 2'd2;
  localparam logic [1:0] LANE_NONE  = 2'd3;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef struct packed {
    logic [1:0] lane;
    logic       powerup;
  } spawn_t;

  // Raw value 3 folds onto the middle lane. An obstacle that would land in the
  // same lane as the previous obstacle is rotated one lane right (mod 3), so
  // the player never faces two obstacles in a row in one lane.
  function automatic logic [1:0] pick_lane(input logic [1:0] raw,
                                           input logic [1:0] last_obs,
                                           input logic       powerup);
    logic [1:0] c;
    c = (raw == 2'd3) ? LANE_MID : raw;
    if (!powerup && c == last_obs)
      return (c == LANE_RIGHT) ? LANE_LEFT : c + 2'd1;
    return c;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR used as the lane random source.
//   clk_in : clock
//   rst_in : async active-high reset, loads SEED
//   q      : current LFSR state (advances every cycle out of reset)
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [15:0] q
);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) q <= SEED;
    else        q <= q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
  end

endmodule

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: paces obstacle/powerup spawns and chooses their lanes.
//   clk_in, rst_in  : clock, async active-high reset
//   pulse           : game tick; spawns are counted in pulses
//   playing         : game in play; falling edge withdraws any offer
//   reset_game      : synchronous clear of scheduler state (LFSR keeps running)
//   time_alive      : ticks survived; drives interval ramp and level
//   spawn_ready     : datapath accepts the current offer
//   spawn_valid     : offer present (held stable until accepted)
//   spawn_lane      : lane 0..2 of the offer
//   spawn_powerup   : 1 = powerup, 0 = obstacle
//   level           : min(15, time_alive >> RAMP_SHIFT), registered
module spawn_scheduler
  import game_pkg::*;
#(
  parameter int unsigned  BASE_INTERVAL = 12,
  parameter int unsigned  MIN_INTERVAL  = 4,
  parameter int unsigned  RAMP_SHIFT    = 5,
  parameter int unsigned  POWERUP_EVERY = 8,
  parameter logic [15:0]  LFSR_SEED     = 16'hACE1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        pulse,
  input  logic        playing,
  input  logic        reset_game,
  input  logic [11:0] time_alive,
  input  logic        spawn_ready,
  output logic        spawn_valid,
  output logic [1:0]  spawn_lane,
  output logic        spawn_powerup,
  output logic [3:0]  level
);

  sched_state_t state, state_nxt;
  logic [7:0]   countdown;
  logic [7:0]   spawn_idx;
  logic [1:0]   last_obs_lane;
  spawn_t       offer_q;
  logic [15:0]  lfsr_q;
  logic         unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .q      (lfsr_q)
  );

  // Only the two low bits feed lane choice.
  assign unused_lfsr = ^lfsr_q[15:2];

  // Interval ramp: compare against the headroom first so BASE - d never wraps.
  logic [11:0] ramp_d;
  logic [7:0]  interval;
  logic [3:0]  level_nxt;
  assign ramp_d = time_alive >> RAMP_SHIFT;

  always_comb begin
    if (ramp_d >= 12'(BASE_INTERVAL - MIN_INTERVAL)) interval = 8'(MIN_INTERVAL);
    else                                             interval = 8'(BASE_INTERVAL) - ramp_d[7:0];
    level_nxt = (ramp_d > 12'd15) ? 4'd15 : ramp_d[3:0];
  end

  logic is_powerup;
  logic last_pulse;
  logic accept;
  assign is_powerup = (spawn_idx == 8'(POWERUP_EVERY - 1));
  assign last_pulse = pulse && (countdown <= 8'd1);
  // Handshake only counts while still playing and not being cleared.
  assign accept     = (state == OFFER) && spawn_ready && playing && !reset_game;

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (reset_game) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (playing) state_nxt = COUNT;
        COUNT:   if (!playing) state_nxt = IDLE;
                 else if (last_pulse) state_nxt = OFFER;
        OFFER:   if (!playing) state_nxt = IDLE;
                 else if (spawn_ready) state_nxt = COUNT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs: valid is exactly "sitting in OFFER", so it can only drop on
  // accept, playing low, reset_game or rst_in.
  always_comb begin
    spawn_valid   = (state == OFFER);
    spawn_lane    = offer_q.lane;
    spawn_powerup = offer_q.powerup;
  end

  // Datapath: countdown, spawn index, obstacle history, latched offer, level.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      countdown     <= '0;
      spawn_idx     <= '0;
      last_obs_lane <= LANE_NONE;
      offer_q       <= '0;
      level         <= '0;
    end else if (reset_game) begin
      countdown     <= '0;
      spawn_idx     <= '0;
      last_obs_lane <= LANE_NONE;
      offer_q       <= '0;
      level         <= '0;
    end else begin
      level <= level_nxt;
      case (state)
        IDLE: if (playing) countdown <= 8'(BASE_INTERVAL);
        COUNT: begin
          if (playing && pulse) begin
            if (countdown > 8'd1) countdown <= countdown - 8'd1;
            else begin
              offer_q.lane    <= pick_lane(lfsr_q[1:0], last_obs_lane, is_powerup);
              offer_q.powerup <= is_powerup;
            end
          end
        end
        OFFER: begin
          // Pulses seen here are dropped; the reload restarts the full interval.
          if (accept) begin
            spawn_idx <= is_powerup ? 8'd0 : spawn_idx + 8'd1;
            if (!offer_q.powerup) last_obs_lane <= offer_q.lane;
            countdown <= interval;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
